johnson_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit Johnson counter's Q bus.
- Registers Q each enabled cycle and decodes it to a one-hot phase plus a phase index.
- Checks that consecutive samples follow the legal Johnson sequence, locks onto a valid sequence, and counts completed revolutions.
- Flags illegal codes and out-of-order jumps (e.g. presets, glitches) for the lab's display and test logic.

---
 rtl/johnson_seq_monitor_pkg.sv | 42 ++++
 rtl/johnson_seq_monitor_decode.sv | 31 +++
 rtl/johnson_seq_monitor.sv | 127 ++++++++++++
 tb/tb_johnson_seq_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_seq_monitor_pkg.sv
// Shared definitions for the Johnson counter sequence monitor.
// Holds the FSM encoding, default sizes and the code-to-index lookup.
// Pure declarations, no state.
package johnson_seq_monitor_pkg;

    localparam int N_DEF        = 4;
    localparam int LOCK_CNT_DEF = 3;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;

    typedef struct packed {
        logic       legal;
        logic [3:0] idx;
    } jdec_t;

    // Code is zero-extended to 8 bits so one function serves any N up to 8.
    // Index k<=n: top k bits set; k>n: top k-n bits clear, rest set.
    function automatic jdec_t johnson_lookup(input logic [7:0] code, input int n);
        jdec_t      r;
        logic [7:0] pat;
        r.legal = 1'b0;
        r.idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (k < 2 * n) begin
                pat = 8'd0;
                for (int b = 0; b < 8; b++) begin
                    if (b < n) begin
                        pat[b] = (k <= n) ? (b >= n - k) : (b < 2 * n - k);
                    end
                end
                if ((code == pat) && !r.legal) begin
                    r.legal = 1'b1;
                    r.idx   = 4'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_seq_monitor_decode.sv
// Combinational Johnson code decoder: legal bit, phase index, one-hot phase.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the input code directly.
module johnson_decode
    import johnson_seq_monitor_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]   code,
    output logic           legal,
    output logic [3:0]     idx,
    output logic [2*N-1:0] onehot
);

    logic [7:0] code_ext;
    jdec_t      dec;

    // Widen the code and look it up; one-hot is blanked on illegal codes.
    always_comb begin
        code_ext         = 8'd0;
        code_ext[N-1:0]  = code;
        dec              = johnson_lookup(code_ext, N);
        legal            = dec.legal;
        idx              = dec.idx;
        onehot           = '0;
        for (int i = 0; i < 2 * N; i++) begin
            onehot[i] = dec.legal && (dec.idx == 4'(i));
        end
    end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson counter sequence monitor: decode, lock, revolution count, error flag.
// Latency: one cycle; all outputs register on the edge that samples q_in with en=1.
// Backpressure: en=0 freezes all state and drops wrap; no flow control otherwise.
module johnson_seq_monitor
    import johnson_seq_monitor_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int CYC_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     q_in,
    input  logic             err_clr,
    output logic [2*N-1:0]   phase,
    output logic [3:0]       phase_idx,
    output logic             legal,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap,
    output logic [CYC_W-1:0] cyc_cnt
);

    logic [1:0]     state, state_nxt;
    logic [2:0]     match, match_nxt;
    logic           err_set, wrap_nxt;
    logic           dec_legal;
    logic [3:0]     dec_idx;
    logic [2*N-1:0] dec_onehot;
    logic [3:0]     succ_idx;
    logic           is_succ, is_stall;

    johnson_decode #(.N(N)) u_dec (
        .code   (q_in),
        .legal  (dec_legal),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // phase_idx doubles as the reference index: it only moves on legal samples.
    always_comb begin
        succ_idx = (phase_idx == 4'(2 * N - 1)) ? 4'd0 : phase_idx + 4'd1;
        is_succ  = dec_legal && (dec_idx == succ_idx);
        is_stall = dec_legal && (dec_idx == phase_idx);
    end

    // Lock FSM: next state, match count, error and wrap events for this sample.
    always_comb begin
        state_nxt = state;
        match_nxt = match;
        err_set   = 1'b0;
        wrap_nxt  = 1'b0;
        case (state)
            SEARCH: begin
                if (!dec_legal) begin
                    state_nxt = FAULT;
                    err_set   = 1'b1;
                end else if (!is_stall) begin
                    match_nxt = is_succ ? match + 3'd1 : 3'd1;
                    if (match_nxt >= 3'(LOCK_CNT)) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!dec_legal) begin
                    state_nxt = FAULT;
                    err_set   = 1'b1;
                end else if (is_succ) begin
                    wrap_nxt = (dec_idx == 4'd0);
                end else if (!is_stall) begin
                    state_nxt = SEARCH;
                    match_nxt = 3'd1;
                    err_set   = 1'b1;
                end
            end
            FAULT: begin
                if (dec_legal) begin
                    state_nxt = SEARCH;
                    match_nxt = 3'd1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                match_nxt = 3'd0;
            end
        endcase
    end

    // Sampled state and output registers; everything holds while en=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            match     <= 3'd0;
            phase     <= '0;
            phase_idx <= 4'd0;
            legal     <= 1'b0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            cyc_cnt   <= '0;
        end else if (en) begin
            state     <= state_nxt;
            match     <= match_nxt;
            phase     <= dec_onehot;
            phase_idx <= dec_legal ? dec_idx : phase_idx;
            legal     <= dec_legal;
            locked    <= (state_nxt == LOCKED);
            wrap      <= wrap_nxt;
            cyc_cnt   <= cyc_cnt + CYC_W'(wrap_nxt);
        end else begin
            wrap      <= 1'b0;
        end
    end

    // Sticky error flag; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err <= 1'b0;
        end else if (en && err_set) begin
            seq_err <= 1'b1;
        end else if (err_clr) begin
            seq_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed bench for johnson_seq_monitor: lock, revolutions, jumps, illegal codes,
// stalls, enable hold, error clear and asynchronous reset.
// Expected values are hand-derived constants per step.
module tb_johnson_seq_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] q_in;
    logic       err_clr;
    logic [7:0] phase;
    logic [3:0] phase_idx;
    logic       legal;
    logic       locked;
    logic       seq_err;
    logic       wrap;
    logic [7:0] cyc_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] jc [8];

    johnson_seq_monitor #(.N(4), .LOCK_CNT(3), .CYC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q_in      (q_in),
        .err_clr   (err_clr),
        .phase     (phase),
        .phase_idx (phase_idx),
        .legal     (legal),
        .locked    (locked),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .cyc_cnt   (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] q);
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_idx, input logic e_legal,
                              input logic e_locked, input logic e_err, input logic e_wrap,
                              input logic [7:0] e_cyc);
        logic [7:0] e_phase;
        e_phase = e_legal ? (8'd1 << e_idx) : 8'd0;
        compared++;
        assert (phase === e_phase) else begin
            mismatched++; $error("FAIL %s phase: observed %b expected %b", tag, phase, e_phase);
        end
        compared++;
        assert (phase_idx === e_idx) else begin
            mismatched++; $error("FAIL %s phase_idx: observed %0d expected %0d", tag, phase_idx, e_idx);
        end
        compared++;
        assert (legal === e_legal) else begin
            mismatched++; $error("FAIL %s legal: observed %b expected %b", tag, legal, e_legal);
        end
        compared++;
        assert (locked === e_locked) else begin
            mismatched++; $error("FAIL %s locked: observed %b expected %b", tag, locked, e_locked);
        end
        compared++;
        assert (seq_err === e_err) else begin
            mismatched++; $error("FAIL %s seq_err: observed %b expected %b", tag, seq_err, e_err);
        end
        compared++;
        assert (wrap === e_wrap) else begin
            mismatched++; $error("FAIL %s wrap: observed %b expected %b", tag, wrap, e_wrap);
        end
        compared++;
        assert (cyc_cnt === e_cyc) else begin
            mismatched++; $error("FAIL %s cyc_cnt: observed %0d expected %0d", tag, cyc_cnt, e_cyc);
        end
    endtask

    task automatic expect_state(input string tag, input logic [1:0] e_state);
        compared++;
        assert (dut.state === e_state) else begin
            mismatched++; $error("FAIL %s state: observed %0d expected %0d", tag, dut.state, e_state);
        end
    endtask

    initial begin
        jc[0] = 4'b0000; jc[1] = 4'b1000; jc[2] = 4'b1100; jc[3] = 4'b1110;
        jc[4] = 4'b1111; jc[5] = 4'b0111; jc[6] = 4'b0011; jc[7] = 4'b0001;

        rst = 1'b0; en = 1'b0; q_in = 4'b0000; err_clr = 1'b0;
        #20;
        expect_out("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_state("reset", 2'd0);
        rst = 1'b1;
        en  = 1'b1;

        // Free run from 0000: lock on the third successor (1110).
        step(jc[0]); expect_out("run0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(jc[1]); expect_out("run1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(jc[2]); expect_out("run2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(jc[3]); expect_out("run3_lock", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 4; k < 8; k++) begin
            step(jc[k]); expect_out("run_locked", 4'(k), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        end
        step(jc[0]); expect_out("wrap1", 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);

        // Two more revolutions; wrap only on the 0001 -> 0000 sample.
        for (int rev = 2; rev <= 3; rev++) begin
            for (int k = 1; k < 8; k++) begin
                step(jc[k]); expect_out("rev_mid", 4'(k), 1'b1, 1'b1, 1'b0, 1'b0, 8'(rev - 1));
            end
            step(jc[0]); expect_out("rev_wrap", 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'(rev));
        end
        step(jc[1]); expect_out("wrap_width", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        step(jc[2]);
        step(jc[3]); expect_out("pre_jump", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);

        // Preset jump to 1000 while locked.
        step(jc[1]); expect_out("jump", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        expect_state("jump", 2'd0);
        step(jc[2]); expect_out("jump_s1", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        step(jc[3]);
        step(jc[4]); expect_out("relock", 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);

        // Illegal code while locked, then recovery through SEARCH.
        step(4'b0101); expect_out("illegal", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        expect_state("illegal", 2'd2);
        step(jc[6]); expect_out("recover", 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        expect_state("recover", 2'd0);
        step(jc[7]); expect_out("recover_s1", 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        step(jc[0]); expect_out("recover_lock", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        step(jc[1]); expect_out("locked_1", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);

        // Error clear on a clean successor, then stall on 1100 for 4 samples total.
        err_clr = 1'b1;
        step(jc[2]); expect_out("err_clr", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        err_clr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step(jc[2]); expect_out("stall", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        end

        // Enable low: q_in wanders, outputs stay frozen.
        en = 1'b0;
        step(4'b0101); expect_out("hold_a", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        step(jc[4]);   expect_out("hold_b", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        step(jc[0]);   expect_out("hold_c", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        step(jc[1]);   expect_out("hold_d", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        step(jc[7]);   expect_out("hold_e", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        en = 1'b1;
        step(jc[3]); expect_out("resume", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);

        // Jump on the same edge as err_clr: error wins.
        err_clr = 1'b1;
        step(jc[6]); expect_out("err_vs_clr", 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        err_clr = 1'b0;
        step(jc[7]); expect_out("relock_s1", 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        step(jc[0]); expect_out("relock_s2", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        step(jc[1]);
        step(jc[2]); expect_out("mid_rev", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);

        // Asynchronous reset mid-revolution, checked before the next edge.
        rst = 1'b0;
        #2;
        expect_out("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_state("async_rst", 2'd0);
        #1;
        rst = 1'b1;
        step(jc[0]); expect_out("post_rst0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(jc[1]); expect_out("post_rst1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_state("post_rst1", 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
